// File: rtl/io_page_fail_pkg.sv
// Shared KS10 bus flag decode for the IO page-fail logic.
// The flag bit positions live here once; consumers call the decode functions.
package io_page_fail_pkg;

    typedef logic [0:35] bus_addr_t;

    localparam int BUS_WRITE_BIT = 5;
    localparam int BUS_WRU_BIT   = 6;
    localparam int BUS_VECT_BIT  = 7;
    localparam int BUS_IO_BIT    = 8;

    function automatic logic bus_io(input bus_addr_t a);
        return a[BUS_IO_BIT];
    endfunction

    function automatic logic bus_write(input bus_addr_t a);
        return a[BUS_WRITE_BIT];
    endfunction

    function automatic logic bus_wru(input bus_addr_t a);
        return a[BUS_WRU_BIT];
    endfunction

    function automatic logic bus_vect(input bus_addr_t a);
        return a[BUS_VECT_BIT];
    endfunction

endpackage

// File: rtl/io_page_fail_sat_counter.sv
// Increment-and-saturate register used for the diagnostic IO fault count.
// Holds at all-ones instead of wrapping.
module io_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [0:W-1] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/io_page_fail.sv
// IO transaction watchdog: times each backplane IO cycle, latches the address of
// an unacknowledged transaction and raises a page-fail request until microcode clears it.
module io_page_fail
    import io_page_fail_pkg::*;
#(
    parameter int TIMEOUT = 12,
    parameter int CNTW    = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [0:35]    cpuADDRO,
    input  logic           cpuREQO,
    input  logic           cpuACKI,
    input  logic           ioBUSY,
    input  logic           ioWAIT,
    input  logic           pfCLR,
    output logic           ioPF,
    output logic [0:35]    pfADDR,
    output logic           pfWRITE,
    output logic [0:CNTW-1] pfCOUNT,
    output logic           ioSTALL
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TIME  = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  tmo_cnt;
    bus_addr_t   cap_addr;
    logic        cap_write;
    logic        no_fault;
    logic        io_pf;
    bus_addr_t   pf_addr;
    logic        pf_write;

    logic        accept;
    logic        cnt_inc;
    logic        fault_evt;
    logic        clr_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: state registers use <= so every flop samples the pre-edge values together.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_nxt = state;
        accept    = 1'b0;
        cnt_inc   = 1'b0;
        fault_evt = 1'b0;
        clr_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (ioBUSY && cpuREQO && bus_io(cpuADDRO) && !cpuACKI) begin
                    accept    = 1'b1;
                    state_nxt = TIME;
                end
            end
            TIME: begin
                // Ack wins over abandonment and over the timeout boundary.
                if (cpuACKI) begin
                    state_nxt = DONE;
                end else if (!ioBUSY) begin
                    state_nxt = IDLE;
                end else if (tmo_cnt == 8'(TIMEOUT)) begin
                    if (no_fault) begin
                        state_nxt = DONE;
                    end else begin
                        fault_evt = 1'b1;
                        state_nxt = FAULT;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                if (!ioBUSY) begin
                    state_nxt = IDLE;
                end
            end
            FAULT: begin
                if (pfCLR) begin
                    clr_evt   = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt   <= 8'd0;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            no_fault  <= 1'b0;
            io_pf     <= 1'b0;
            pf_addr   <= '0;
            pf_write  <= 1'b0;
        end else begin
            if (accept) begin
                cap_addr  <= cpuADDRO;
                cap_write <= bus_write(cpuADDRO);
                no_fault  <= bus_wru(cpuADDRO) | bus_vect(cpuADDRO);
                tmo_cnt   <= 8'd1;
            end else if (cnt_inc) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end

            // pfADDR/pfWRITE survive a clear so microcode can still read them.
            if (fault_evt) begin
                io_pf    <= 1'b1;
                pf_addr  <= cap_addr;
                pf_write <= cap_write;
            end else if (clr_evt) begin
                io_pf <= 1'b0;
            end
        end
    end

    io_sat_counter #(
        .W (CNTW)
    ) u_fault_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fault_evt),
        .count (pfCOUNT)
    );

    assign ioPF    = io_pf;
    assign pfADDR  = pf_addr;
    assign pfWRITE = pf_write;
    assign ioSTALL = ((state == TIME) && !cpuACKI) || ioWAIT;

endmodule

// File: tb/tb_io_page_fail.sv
// Randomized self-checking bench for io_page_fail against a transaction-level model.
module tb_io_page_fail;

    localparam int TIMEOUT = 12;
    localparam int CNTW    = 2;
    localparam int B_WRITE = 5;
    localparam int B_WRU   = 6;
    localparam int B_VECT  = 7;
    localparam int B_IO    = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [0:35]     cpuADDRO;
    logic            cpuREQO, cpuACKI, ioBUSY, ioWAIT, pfCLR;
    logic            ioPF, pfWRITE, ioSTALL;
    logic [0:35]     pfADDR;
    logic [0:CNTW-1] pfCOUNT;

    int errors = 0;
    int checks = 0;

    logic [0:35] m_addr;
    logic        m_write;
    int          m_faults;

    io_page_fail #(
        .TIMEOUT (TIMEOUT),
        .CNTW    (CNTW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpuADDRO (cpuADDRO),
        .cpuREQO  (cpuREQO),
        .cpuACKI  (cpuACKI),
        .ioBUSY   (ioBUSY),
        .ioWAIT   (ioWAIT),
        .pfCLR    (pfCLR),
        .ioPF     (ioPF),
        .pfADDR   (pfADDR),
        .pfWRITE  (pfWRITE),
        .pfCOUNT  (pfCOUNT),
        .ioSTALL  (ioSTALL)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [0:35] mk_addr(input logic [21:0] a, input bit io, input bit wr,
                                            input bit wru, input bit vect);
        logic [0:35] x;
        x         = '0;
        x[14:35]  = a;
        x[B_IO]   = io;
        x[B_WRITE] = wr;
        x[B_WRU]  = wru;
        x[B_VECT] = vect;
        return x;
    endfunction

    function automatic int exp_count();
        int sat;
        sat = (1 << CNTW) - 1;
        return (m_faults > sat) ? sat : m_faults;
    endfunction

    task automatic check_held(input string tag);
        check({tag, "_addr"},  64'(pfADDR),  64'(m_addr));
        check({tag, "_write"}, 64'(pfWRITE), 64'(m_write));
        check({tag, "_count"}, 64'(pfCOUNT), 64'(exp_count()));
    endtask

    task automatic idle_inputs();
        cpuADDRO = '0;
        cpuREQO  = 1'b0;
        cpuACKI  = 1'b0;
        ioBUSY   = 1'b0;
        ioWAIT   = 1'b0;
        pfCLR    = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            ioWAIT = 1'($urandom);
            @(negedge clk);
            check("idle_stall", 64'(ioSTALL), 64'(ioWAIT));
            check("idle_pf", 64'(ioPF), 64'd0);
            check_held("idle");
        end
    endtask

    // One IO transaction: ack_at/drop_at are cycle numbers after acceptance (0 = never).
    task automatic run_txn(input logic [0:35] addr, input int ack_at, input int drop_at);
        bit wr, nofault, fault;
        int last;
        wr      = addr[B_WRITE];
        nofault = addr[B_WRU] | addr[B_VECT];
        last    = TIMEOUT;
        if (ack_at > 0 && ack_at < last) last = ack_at;
        if (drop_at > 0 && drop_at < last) last = drop_at;
        fault = !nofault && !(ack_at >= 1 && ack_at <= TIMEOUT)
                         && !(drop_at >= 1 && drop_at <= TIMEOUT);

        @(posedge clk); #1;
        cpuADDRO = addr; cpuREQO = 1'b1; ioBUSY = 1'b1; cpuACKI = 1'b0; pfCLR = 1'b0;
        ioWAIT = 1'($urandom);
        @(negedge clk);
        check("req_stall", 64'(ioSTALL), 64'(ioWAIT));
        check("req_pf", 64'(ioPF), 64'd0);

        for (int t = 1; t <= TIMEOUT; t++) begin
            @(posedge clk); #1;
            cpuADDRO = mk_addr(22'($urandom), 1'b1, 1'($urandom), 1'b0, 1'b0);
            ioBUSY   = (drop_at == 0) || (t < drop_at);
            cpuACKI  = (t == ack_at);
            pfCLR    = ($urandom % 5) == 0;
            ioWAIT   = 1'($urandom);
            @(negedge clk);
            check("time_stall", 64'(ioSTALL), 64'(((t <= last) && !cpuACKI) || ioWAIT));
            check("time_pf", 64'(ioPF), 64'd0);
            check_held("time");
        end

        @(posedge clk); #1;
        cpuACKI = 1'b0; pfCLR = 1'b0; ioWAIT = 1'($urandom);
        if (fault) begin
            m_addr  = addr;
            m_write = wr;
            m_faults++;
            cpuREQO = 1'b1; ioBUSY = 1'b1;
            @(negedge clk);
            check("fault_pf", 64'(ioPF), 64'd1);
            check("fault_stall", 64'(ioSTALL), 64'(ioWAIT));
            check_held("fault");
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                cpuADDRO = mk_addr(22'($urandom), 1'b1, 1'($urandom), 1'b0, 1'b0);
                cpuACKI  = 1'($urandom);
                ioWAIT   = 1'($urandom);
                @(negedge clk);
                check("lock_pf", 64'(ioPF), 64'd1);
                check("lock_stall", 64'(ioSTALL), 64'(ioWAIT));
                check_held("lock");
            end
            @(posedge clk); #1;
            cpuACKI = 1'b0; pfCLR = 1'b1;
            @(negedge clk);
            check("clr_cycle_pf", 64'(ioPF), 64'd1);
            for (int i = 0; i < 2; i++) begin
                @(posedge clk); #1;
                pfCLR  = 1'b0;
                ioWAIT = 1'($urandom);
                @(negedge clk);
                check("after_clr_pf", 64'(ioPF), 64'd0);
                check("after_clr_stall", 64'(ioSTALL), 64'(ioWAIT));
                check_held("after_clr");
            end
        end else begin
            cpuREQO = 1'b0; ioBUSY = 1'b0;
            @(negedge clk);
            check("nofault_pf", 64'(ioPF), 64'd0);
            check("nofault_stall", 64'(ioSTALL), 64'(ioWAIT));
            check_held("nofault");
        end
        idle_cycles(2);
    endtask

    initial begin
        int ack_at, drop_at;
        bit wru, vect;

        rst = 1'b1;
        idle_inputs();
        m_addr = '0; m_write = 1'b0; m_faults = 0;
        #12;
        check("rst_pf", 64'(ioPF), 64'd0);
        check("rst_stall", 64'(ioSTALL), 64'd0);
        check_held("rst");
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        run_txn(mk_addr(22'o3777000, 1'b1, 1'b0, 1'b0, 1'b0), 5, 0);
        run_txn(mk_addr(22'o1776120, 1'b1, 1'b1, 1'b0, 1'b0), 0, 0);
        run_txn(mk_addr(22'o1776124, 1'b1, 1'b0, 1'b0, 1'b0), TIMEOUT, 0);
        run_txn(mk_addr(22'o0000000, 1'b1, 1'b0, 1'b1, 1'b0), 0, 0);
        run_txn(mk_addr(22'o0000001, 1'b1, 1'b0, 1'b0, 1'b1), 0, 0);
        run_txn(mk_addr(22'o1776200, 1'b1, 1'b0, 1'b0, 1'b0), 0, 4);

        // Request acknowledged in the acceptance cycle is never timed.
        @(posedge clk); #1;
        cpuADDRO = mk_addr(22'o3777010, 1'b1, 1'b0, 1'b0, 1'b0);
        cpuREQO = 1'b1; ioBUSY = 1'b1; cpuACKI = 1'b1; ioWAIT = 1'b0;
        @(negedge clk);
        check("sameack_stall0", 64'(ioSTALL), 64'd0);
        @(posedge clk); #1;
        cpuREQO = 1'b0; cpuACKI = 1'b0;
        @(negedge clk);
        check("sameack_stall1", 64'(ioSTALL), 64'd0);
        idle_cycles(1);

        for (int i = 0; i < 3; i++)
            run_txn(mk_addr(22'($urandom), 1'b1, 1'($urandom), 1'b0, 1'b0), 0, 0);

        for (int i = 0; i < 30; i++) begin
            wru     = ($urandom % 6) == 0;
            vect    = ($urandom % 6) == 0;
            ack_at  = (($urandom % 3) == 0) ? 0 : $urandom_range(1, TIMEOUT);
            drop_at = (($urandom % 4) == 0) ? $urandom_range(1, TIMEOUT + 1) : 0;
            run_txn(mk_addr(22'($urandom), 1'b1, 1'($urandom), wru, vect), ack_at, drop_at);
        end

        // Asynchronous reset in cycle 7 of a timed transaction.
        @(posedge clk); #1;
        cpuADDRO = mk_addr(22'o1776500, 1'b1, 1'b1, 1'b0, 1'b0);
        cpuREQO = 1'b1; ioBUSY = 1'b1; cpuACKI = 1'b0; ioWAIT = 1'b0; pfCLR = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("prerst_stall", 64'(ioSTALL), 64'd1);
        end
        #2;
        rst = 1'b1;
        #1;
        m_addr = '0; m_write = 1'b0; m_faults = 0;
        check("midrst_pf", 64'(ioPF), 64'd0);
        check("midrst_stall", 64'(ioSTALL), 64'd0);
        check_held("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        idle_cycles(1);

        run_txn(mk_addr(22'o1776502, 1'b1, 1'b1, 1'b0, 1'b0), 0, 0);
        for (int i = 0; i < 15; i++) begin
            ack_at  = (($urandom % 2) == 0) ? 0 : $urandom_range(1, TIMEOUT);
            drop_at = (($urandom % 5) == 0) ? $urandom_range(1, TIMEOUT + 1) : 0;
            run_txn(mk_addr(22'($urandom), 1'b1, 1'($urandom), 1'b0, 1'b0), ack_at, drop_at);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
